// File: rtl/bus_sequencer.sv
// ============================================================================
// Module   : bus_sequencer
// Brief    : Latches one CPU load/store and runs it on the shared peripheral bus.
//            The select is held until the addressed device is ready, and the CPU
//            is stalled for the whole access. Optional macro BUS_TIMEOUT_EN adds
//            a wait counter that aborts an access to ERR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_sequencer #(
    parameter int         DEV_SHIFT = 12,
    parameter logic [3:0] DEV_MASK  = 4'b1111,
    parameter int         TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_w,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [3:0]  bus_select,
    output logic        bus_w,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic [3:0]  bus_ready
);

    // The wait counter is 8 bits wide, so TIMEOUT must fit in 1..255.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_sequencer: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_w;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx;
    logic        w_valid;
    logic        w_ready;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_cnt;
`endif

    // Anything above the device-index field must be zero for a legal address.
    assign w_idx   = cpu_addr[DEV_SHIFT+1:DEV_SHIFT];
    assign w_valid = ((cpu_addr >> (DEV_SHIFT + 2)) == 32'd0) && DEV_MASK[w_idx];
    assign w_ready = bus_ready[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_w     <= 1'b0;
            r_idx   <= 2'd0;
`ifdef BUS_TIMEOUT_EN
            r_cnt   <= 8'd0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && cpu_req) begin
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
                r_w     <= cpu_w;
                r_idx   <= w_idx;
            end
            // Stores return zero so a stale load value never leaks to the CPU.
            if (r_state == S_ACCESS && w_ready) begin
                r_rdata <= r_w ? 32'd0 : bus_rdata;
            end
`ifdef BUS_TIMEOUT_EN
            if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
`endif
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_next = w_valid ? S_ACCESS : S_ERR;
                end
            end
            S_ACCESS: begin
                // Ready takes priority over an expiring timeout.
                if (w_ready) begin
                    w_next = S_DONE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (r_cnt == C_CNT_LAST) begin
                    w_next = S_ERR;
                end
`endif
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus_select = 4'b0000;
        bus_w      = 1'b0;
        cpu_ack    = 1'b0;
        cpu_err    = 1'b0;
        cpu_rdata  = 32'd0;
        if (r_state == S_ACCESS) begin
            bus_select = 4'b0001 << r_idx;
            bus_w      = r_w;
        end
        if (r_state == S_DONE) begin
            cpu_ack   = 1'b1;
            cpu_rdata = r_rdata;
        end
        if (r_state == S_ERR) begin
            cpu_ack = 1'b1;
            cpu_err = 1'b1;
        end
    end

    // Gated by rst so the stall drops the moment reset is applied.
    assign cpu_stall = !rst && ((r_state == S_IDLE && cpu_req) || r_state == S_ACCESS);
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_bus_sequencer.sv
// ============================================================================
// Module   : tb_bus_sequencer
// Brief    : Directed self-checking bench for bus_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_req2, cpu_w;
    logic [31:0] cpu_addr, cpu_wdata, bus_rdata;
    logic [3:0]  bus_ready;

    logic [31:0] cpu_rdata, bus_addr, bus_wdata;
    logic        cpu_stall, cpu_ack, cpu_err, bus_w;
    logic [3:0]  bus_select;

    logic [31:0] cpu_rdata2, bus_addr2, bus_wdata2;
    logic        cpu_stall2, cpu_ack2, cpu_err2, bus_w2;
    logic [3:0]  bus_select2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_sequencer u_dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_w(cpu_w),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .bus_select(bus_select), .bus_w(bus_w), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    bus_sequencer #(.DEV_MASK(4'b0111)) u_dut_mask (
        .clk(clk), .rst(rst), .cpu_req(cpu_req2), .cpu_w(cpu_w),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata2),
        .cpu_stall(cpu_stall2), .cpu_ack(cpu_ack2), .cpu_err(cpu_err2),
        .bus_select(bus_select2), .bus_w(bus_w2), .bus_addr(bus_addr2),
        .bus_wdata(bus_wdata2), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_req2 = 1'b0; cpu_w = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; bus_rdata = 32'd0; bus_ready = 4'b0000;
        cyc(); cyc();
        mid();
        chk32("rst_rdata", cpu_rdata, 32'd0);
        chk1("rst_stall", cpu_stall, 1'b0);
        chk1("rst_ack", cpu_ack, 1'b0);
        chk1("rst_err", cpu_err, 1'b0);
        chk4("rst_select", bus_select, 4'b0000);
        chk1("rst_bus_w", bus_w, 1'b0);
        chk32("rst_bus_addr", bus_addr, 32'd0);
        chk32("rst_bus_wdata", bus_wdata, 32'd0);
        cyc(); rst = 1'b0;
        cyc();

        // Load from device 1, ready immediately
        cpu_req = 1'b1; cpu_w = 1'b0; cpu_addr = 32'h0000_1004;
        bus_ready = 4'b0010; bus_rdata = 32'h1234_5678;
        mid();
        chk1("ld_c0_stall", cpu_stall, 1'b1);
        chk4("ld_c0_select", bus_select, 4'b0000);
        cyc(); mid();
        chk4("ld_c1_select", bus_select, 4'b0010);
        chk1("ld_c1_stall", cpu_stall, 1'b1);
        chk1("ld_c1_ack", cpu_ack, 1'b0);
        chk32("ld_c1_bus_addr", bus_addr, 32'h0000_1004);
        cyc(); mid();
        chk1("ld_c2_ack", cpu_ack, 1'b1);
        chk1("ld_c2_err", cpu_err, 1'b0);
        chk32("ld_c2_rdata", cpu_rdata, 32'h1234_5678);
        chk1("ld_c2_stall", cpu_stall, 1'b0);
        chk4("ld_c2_select", bus_select, 4'b0000);
        cyc(); cpu_req = 1'b0; bus_ready = 4'b0000; mid();
        chk1("ld_c3_ack", cpu_ack, 1'b0);

        // Store to device 2, ready after 3 wait cycles
        cyc();
        cpu_req = 1'b1; cpu_w = 1'b1; cpu_addr = 32'h0000_2000; cpu_wdata = 32'hA5A5_A5A5;
        bus_rdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (i == 4) bus_ready = 4'b0100;
            mid();
            chk4("st_select", bus_select, 4'b0100);
            chk1("st_bus_w", bus_w, 1'b1);
            chk32("st_bus_wdata", bus_wdata, 32'hA5A5_A5A5);
            chk1("st_ack_early", cpu_ack, 1'b0);
        end
        cyc(); mid();
        chk1("st_c5_ack", cpu_ack, 1'b1);
        chk1("st_c5_err", cpu_err, 1'b0);
        chk32("st_c5_rdata", cpu_rdata, 32'd0);
        chk1("st_c5_bus_w", bus_w, 1'b0);
        cyc(); cpu_req = 1'b0; cpu_w = 1'b0; bus_ready = 4'b0000;

        // Decode error: high address bits set
        cyc();
        cpu_req = 1'b1; cpu_addr = 32'h0000_4000; bus_ready = 4'b1111; bus_rdata = 32'h5555_5555;
        mid();
        chk4("de_c0_select", bus_select, 4'b0000);
        cyc(); mid();
        chk1("de_c1_ack", cpu_ack, 1'b1);
        chk1("de_c1_err", cpu_err, 1'b1);
        chk32("de_c1_rdata", cpu_rdata, 32'd0);
        chk4("de_c1_select", bus_select, 4'b0000);
        cyc(); cpu_req = 1'b0; bus_ready = 4'b0000; mid();
        chk4("de_c2_select", bus_select, 4'b0000);
        chk1("de_c2_ack", cpu_ack, 1'b0);

        // Decode error: unpopulated device 3 on the masked instance
        cyc();
        cpu_req2 = 1'b1; cpu_addr = 32'h0000_3000; bus_ready = 4'b1111;
        cyc(); mid();
        chk1("dm_c1_ack", cpu_ack2, 1'b1);
        chk1("dm_c1_err", cpu_err2, 1'b1);
        chk32("dm_c1_rdata", cpu_rdata2, 32'd0);
        chk4("dm_c1_select", bus_select2, 4'b0000);
        cyc(); cpu_req2 = 1'b0; bus_ready = 4'b0000; mid();
        chk4("dm_c2_select", bus_select2, 4'b0000);

        // Device 0 never ready; other ready bits must be ignored
        cyc();
        cpu_req = 1'b1; cpu_addr = 32'h0000_0000; bus_ready = 4'b1110; bus_rdata = 32'h0F0F_0F0F;
`ifdef BUS_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i == 2) cpu_req = 1'b0;
            mid();
            chk4("to_select", bus_select, 4'b0001);
            chk1("to_ack_early", cpu_ack, 1'b0);
        end
        cyc(); mid();
        chk1("to_ack", cpu_ack, 1'b1);
        chk1("to_err", cpu_err, 1'b1);
        chk4("to_select_off", bus_select, 4'b0000);
        cyc(); mid();
        chk1("to_idle_ack", cpu_ack, 1'b0);
        // Ready on the final permitted cycle completes normally
        cpu_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i == 16) bus_ready = 4'b0001;
            mid();
            chk4("tr_select", bus_select, 4'b0001);
        end
        cyc(); mid();
        chk1("tr_ack", cpu_ack, 1'b1);
        chk1("tr_err", cpu_err, 1'b0);
        chk32("tr_rdata", cpu_rdata, 32'h0F0F_0F0F);
`else
        for (int i = 1; i <= 24; i++) begin
            cyc();
            if (i == 2) cpu_req = 1'b0;
            if (i == 24) bus_ready = 4'b0001;
            mid();
            chk4("nt_select", bus_select, 4'b0001);
            chk1("nt_ack_early", cpu_ack, 1'b0);
        end
        cyc(); mid();
        chk1("nt_ack", cpu_ack, 1'b1);
        chk1("nt_err", cpu_err, 1'b0);
        chk32("nt_rdata", cpu_rdata, 32'h0F0F_0F0F);
`endif
        cyc(); cpu_req = 1'b0; bus_ready = 4'b0000;

        // Back-to-back, bus_ready[3] toggling every cycle
        cyc();
        cpu_req = 1'b1; cpu_addr = 32'h0000_1004; bus_rdata = 32'h1111_2222; bus_ready = 4'b0010;
        cyc(); bus_ready = 4'b1010; mid();
        chk4("bb_c1_select", bus_select, 4'b0010);
        cyc(); bus_ready = 4'b0010; cpu_addr = 32'h0000_1000; mid();
        chk1("bb_c2_ack", cpu_ack, 1'b1);
        chk32("bb_c2_rdata", cpu_rdata, 32'h1111_2222);
        chk1("bb_c2_stall", cpu_stall, 1'b0);
        cyc(); bus_ready = 4'b1010; bus_rdata = 32'hCAFE_BABE; mid();
        chk1("bb_c3_stall", cpu_stall, 1'b1);
        chk4("bb_c3_select", bus_select, 4'b0000);
        chk1("bb_c3_ack", cpu_ack, 1'b0);
        cyc(); bus_ready = 4'b0010; mid();
        chk4("bb_c4_select", bus_select, 4'b0010);
        chk32("bb_c4_bus_addr", bus_addr, 32'h0000_1000);
        cyc(); bus_ready = 4'b1000; mid();
        chk1("bb_c5_ack", cpu_ack, 1'b1);
        chk32("bb_c5_rdata", cpu_rdata, 32'hCAFE_BABE);
        cyc(); cpu_req = 1'b0; bus_ready = 4'b0000;

        // Reset during an access
        cyc();
        cpu_req = 1'b1; cpu_addr = 32'h0000_2000;
        cyc(); mid();
        chk4("ra_c1_select", bus_select, 4'b0100);
        cyc(); rst = 1'b1; #1;
        chk4("ra_select", bus_select, 4'b0000);
        chk1("ra_stall", cpu_stall, 1'b0);
        chk1("ra_ack", cpu_ack, 1'b0);
        chk32("ra_bus_addr", bus_addr, 32'd0);
        mid();
        chk1("ra_mid_ack", cpu_ack, 1'b0);
        cyc(); rst = 1'b0;
        cpu_addr = 32'h0000_1004; bus_ready = 4'b0010; bus_rdata = 32'h0BAD_F00D;
        mid();
        chk1("rr_c0_stall", cpu_stall, 1'b1);
        cyc(); mid();
        chk4("rr_c1_select", bus_select, 4'b0010);
        cyc(); mid();
        chk1("rr_c2_ack", cpu_ack, 1'b1);
        chk1("rr_c2_err", cpu_err, 1'b0);
        chk32("rr_c2_rdata", cpu_rdata, 32'h0BAD_F00D);
        cyc(); cpu_req = 1'b0; bus_ready = 4'b0000;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
